// File: rtl/fifo_status_pkg.sv
// Shared constants for the FIFO occupancy/status generator: default sizing,
// FIFO bit positions and the threshold-load state machine encoding.
package fifo_status_pkg;

    localparam int DEPTH_DEF = 16;
    localparam int CNT_W_DEF = 5;
    localparam int NUM_F_DEF = 5;

    localparam int MF  = 0;
    localparam int VC0 = 1;
    localparam int VC1 = 2;
    localparam int D0  = 3;
    localparam int D1  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_occ_counter.sv
// Occupancy counter for a single FIFO: saturating count from push/pop strobes,
// overflow/underflow event, and registered empty/full/almost flags from next count.
module fifo_occ_counter #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flag_en,
    input  logic [CNT_W-1:0] low,
    input  logic [CNT_W-1:0] high,
    output logic [CNT_W-1:0] count,
    output logic             err_evt,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] next_cnt_s;

    // Next count and error event; a pop on empty is rejected while a paired push still lands.
    always_comb begin
        next_cnt_s = count;
        err_evt    = 1'b0;
        case ({push, pop})
            2'b10: begin
                if (count < DEPTH_C) begin
                    next_cnt_s = count + ONE_C;
                end else begin
                    err_evt = 1'b1;
                end
            end
            2'b01: begin
                if (count > ZERO_C) begin
                    next_cnt_s = count - ONE_C;
                end else begin
                    err_evt = 1'b1;
                end
            end
            2'b11: begin
                if (count == ZERO_C) begin
                    next_cnt_s = ONE_C;
                    err_evt    = 1'b1;
                end else begin
                    next_cnt_s = count;
                end
            end
            default: begin
                next_cnt_s = count;
            end
        endcase
    end

    // Count register and flags, all derived from the next count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count        <= ZERO_C;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b0;
            almost_full  <= 1'b0;
        end else begin
            count        <= next_cnt_s;
            empty        <= (next_cnt_s == ZERO_C);
            full         <= (next_cnt_s == DEPTH_C);
            almost_empty <= flag_en && (next_cnt_s <= low);
            almost_full  <= flag_en && (next_cnt_s >= high);
        end
    end

endmodule

// File: rtl/fifo_status_gen.sv
// Status generator for the five datapath FIFOs: threshold load FSM, shadow
// watermarks, sticky error vector, and one occupancy counter per FIFO.
module fifo_status_gen
    import fifo_status_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int NUM_F = NUM_F_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             active_in,
    input  logic             err_clr,
    input  logic [NUM_F-1:0] push,
    input  logic [NUM_F-1:0] pop,
    input  logic [CNT_W-1:0] mf_l,
    input  logic [CNT_W-1:0] mf_h,
    input  logic [CNT_W-1:0] vco_l,
    input  logic [CNT_W-1:0] vco_h,
    input  logic [CNT_W-1:0] vc1_l,
    input  logic [CNT_W-1:0] vc1_h,
    input  logic [CNT_W-1:0] do_l,
    input  logic [CNT_W-1:0] do_h,
    input  logic [CNT_W-1:0] d1_l,
    input  logic [CNT_W-1:0] d1_h,
    output logic [NUM_F-1:0] empties,
    output logic [NUM_F-1:0] fulls,
    output logic [NUM_F-1:0] almost_empty,
    output logic [NUM_F-1:0] almost_full,
    output logic [NUM_F-1:0] errors,
    output logic             cfg_err,
    output logic             run_out,
    output logic [CNT_W-1:0] count_mf,
    output logic [CNT_W-1:0] count_vc0,
    output logic [CNT_W-1:0] count_vc1,
    output logic [CNT_W-1:0] count_d0,
    output logic [CNT_W-1:0] count_d1
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    state_t           state_r;
    logic [CNT_W-1:0] thr_low_s   [NUM_F];
    logic [CNT_W-1:0] thr_high_s  [NUM_F];
    logic [CNT_W-1:0] shadow_low_r  [NUM_F];
    logic [CNT_W-1:0] shadow_high_r [NUM_F];
    logic [CNT_W-1:0] cmp_low_s   [NUM_F];
    logic [CNT_W-1:0] cmp_high_s  [NUM_F];
    logic [CNT_W-1:0] count_s     [NUM_F];
    logic [NUM_F-1:0] valid_s;
    logic [NUM_F-1:0] err_evt_s;
    logic             all_valid_s;
    logic             flag_en_s;

    assign thr_low_s[MF]   = mf_l;
    assign thr_high_s[MF]  = mf_h;
    assign thr_low_s[VC0]  = vco_l;
    assign thr_high_s[VC0] = vco_h;
    assign thr_low_s[VC1]  = vc1_l;
    assign thr_high_s[VC1] = vc1_h;
    assign thr_low_s[D0]   = do_l;
    assign thr_high_s[D0]  = do_h;
    assign thr_low_s[D1]   = d1_l;
    assign thr_high_s[D1]  = d1_h;

    assign count_mf  = count_s[MF];
    assign count_vc0 = count_s[VC0];
    assign count_vc1 = count_s[VC1];
    assign count_d0  = count_s[D0];
    assign count_d1  = count_s[D1];

    assign all_valid_s = &valid_s;

    // Flags follow the state the FSM is entering, so almost_* go live together with run_out.
    assign flag_en_s = ((state_r == ST_LOAD) && all_valid_s) ||
                       ((state_r == ST_RUN) && active_in);

    for (genvar i = 0; i < NUM_F; i++) begin : g_fifo
        assign valid_s[i]    = (thr_low_s[i] <= thr_high_s[i]) && (thr_high_s[i] <= DEPTH_C);
        assign cmp_low_s[i]  = (state_r == ST_LOAD) ? thr_low_s[i]  : shadow_low_r[i];
        assign cmp_high_s[i] = (state_r == ST_LOAD) ? thr_high_s[i] : shadow_high_r[i];

        fifo_occ_counter #(
            .DEPTH (DEPTH),
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk          (clk),
            .reset        (reset),
            .push         (push[i]),
            .pop          (pop[i]),
            .flag_en      (flag_en_s),
            .low          (cmp_low_s[i]),
            .high         (cmp_high_s[i]),
            .count        (count_s[i]),
            .err_evt      (err_evt_s[i]),
            .empty        (empties[i]),
            .full         (fulls[i]),
            .almost_empty (almost_empty[i]),
            .almost_full  (almost_full[i])
        );
    end

    // Threshold load FSM with shadow capture and registered run/config-error outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            run_out <= 1'b0;
            cfg_err <= 1'b0;
            for (int i = 0; i < NUM_F; i++) begin
                shadow_low_r[i]  <= {CNT_W{1'b0}};
                shadow_high_r[i] <= DEPTH_C;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    run_out <= 1'b0;
                    state_r <= active_in ? ST_LOAD : ST_IDLE;
                end
                ST_LOAD: begin
                    for (int i = 0; i < NUM_F; i++) begin
                        shadow_low_r[i]  <= thr_low_s[i];
                        shadow_high_r[i] <= thr_high_s[i];
                    end
                    if (all_valid_s) begin
                        state_r <= ST_RUN;
                        run_out <= 1'b1;
                        cfg_err <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                        run_out <= 1'b0;
                        cfg_err <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!active_in) begin
                        state_r <= ST_IDLE;
                        run_out <= 1'b0;
                    end else begin
                        state_r <= ST_RUN;
                        run_out <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    run_out <= 1'b0;
                end
            endcase
        end
    end

    // Sticky errors; a fresh event outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            errors <= {NUM_F{1'b0}};
        end else begin
            errors <= (errors & ~{NUM_F{err_clr}}) | err_evt_s;
        end
    end

endmodule
